mc_controller: RTL and testbench

Multi-cycle MIPS control unit that sits directly upstream of the ALU and the rest of the multi-cycle datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states, and drives every datapath enable and mux select. It produces the ALU's 4-bit function code and uses the ALU's `zero` flag to resolve branches. It adds a memory-ready handshake, so fetch and data accesses can stall on slow memory.

---
 rtl/mc_controller.sv | 199 +++++++++++++++++++
 tb/tb_mc_controller.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives every datapath enable and select, stalling on a memory-ready handshake.
module mc_controller (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       pcen,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [3:0] alucontrol,
  output logic       illegal,
  output logic [3:0] dbg_state
);

  // Memory handshake: mem_req is high for the whole access; the access
  // completes in the cycle mem_ready is sampled high, otherwise the state holds.

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMRD    = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWR    = 4'd5;
  localparam logic [3:0] S_RTEXEC   = 4'd6;
  localparam logic [3:0] S_RTWB     = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_ADDIEXEC = 4'd9;
  localparam logic [3:0] S_ADDIWB   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  logic [3:0] state, next_state;
  logic       is_load;
  logic       rt_legal;
  logic [3:0] rt_alu;

  logic mem_req_raw, memwrite_raw, irwrite_raw, regwrite_raw, pcen_raw, illegal_raw;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_FETCH;
      is_load <= 1'b0;
    end else begin
      state <= next_state;
      // MEMADR needs lw/sw without re-reading op, so remember it at decode
      if (state == S_DECODE) is_load <= (op == OP_LW);
    end
  end

  always_comb begin
    rt_legal = 1'b1;
    rt_alu   = ALU_ADD;
    case (funct)
      6'b100000: rt_alu = ALU_ADD;
      6'b100010: rt_alu = ALU_SUB;
      6'b100100: rt_alu = ALU_AND;
      6'b100101: rt_alu = ALU_OR;
      6'b101010: rt_alu = ALU_SLT;
      6'b101011: rt_alu = ALU_SLTU;
      default:   rt_legal = 1'b0;
    endcase
  end

  always_comb begin
    next_state   = state;
    mem_req_raw  = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    pcen_raw     = 1'b0;
    illegal_raw  = 1'b0;
    iord         = 1'b0;
    memtoreg     = 1'b0;
    regdst       = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    alucontrol   = ALU_ADD;
    case (state)
      S_FETCH: begin
        mem_req_raw = 1'b1;
        alusrcb     = 2'b01;
        irwrite_raw = mem_ready;
        pcen_raw    = mem_ready;
        if (mem_ready) next_state = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW:   next_state = S_MEMADR;
          OP_BEQ, OP_BNE: next_state = S_BRANCH;
          OP_ADDI:        next_state = S_ADDIEXEC;
          OP_J:           next_state = S_JUMP;
          OP_RTYPE: begin
            if (rt_legal) begin
              next_state = S_RTEXEC;
            end else begin
              illegal_raw = 1'b1;
              next_state  = S_FETCH;
            end
          end
          default: begin
            illegal_raw = 1'b1;
            next_state  = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        next_state = is_load ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req_raw = 1'b1;
        iord        = 1'b1;
        if (mem_ready) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite_raw = 1'b1;
        memtoreg     = 1'b1;
        next_state   = S_FETCH;
      end
      S_MEMWR: begin
        mem_req_raw  = 1'b1;
        memwrite_raw = 1'b1;
        iord         = 1'b1;
        if (mem_ready) next_state = S_FETCH;
      end
      S_RTEXEC: begin
        alusrca    = 1'b1;
        alucontrol = rt_alu;
        next_state = S_RTWB;
      end
      S_RTWB: begin
        regwrite_raw = 1'b1;
        regdst       = 1'b1;
        next_state   = S_FETCH;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        pcen_raw   = (op == OP_BNE) ? ~zero : zero;
        next_state = S_FETCH;
      end
      S_ADDIEXEC: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        next_state = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite_raw = 1'b1;
        next_state   = S_FETCH;
      end
      S_JUMP: begin
        pcsrc      = 2'b10;
        pcen_raw   = 1'b1;
        next_state = S_FETCH;
      end
      default: next_state = S_FETCH;
    endcase
  end

  // Strobes are gated by reset directly so they drop the instant reset_n falls;
  // selects already show FETCH values because the state resets asynchronously.
  assign mem_req   = mem_req_raw  & reset_n;
  assign memwrite  = memwrite_raw & reset_n;
  assign irwrite   = irwrite_raw  & reset_n;
  assign regwrite  = regwrite_raw & reset_n;
  assign pcen      = pcen_raw     & reset_n;
  assign illegal   = illegal_raw  & reset_n;
  assign dbg_state = state;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: per-cycle comparison of the full control
// vector against hand-derived expectations for each instruction class.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, memwrite, irwrite, regwrite, pcen, iord, memtoreg, regdst, alusrca, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [3:0] alucontrol;
  logic [3:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .memwrite(memwrite),
    .irwrite(irwrite), .regwrite(regwrite), .pcen(pcen), .iord(iord),
    .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
    .illegal(illegal), .dbg_state(dbg_state)
  );

  // {mem_req,memwrite,irwrite,regwrite,pcen,iord,memtoreg,regdst,alusrca, alusrcb, pcsrc, alucontrol, illegal}
  logic [17:0] ctl;
  assign ctl = {mem_req, memwrite, irwrite, regwrite, pcen, iord, memtoreg, regdst, alusrca,
                alusrcb, pcsrc, alucontrol, illegal};

  localparam logic [17:0] F1   = 18'b101010000_01_00_0010_0;
  localparam logic [17:0] F0   = 18'b100000000_01_00_0010_0;
  localparam logic [17:0] RST  = 18'b000000000_01_00_0010_0;
  localparam logic [17:0] DEC  = 18'b000000000_11_00_0010_0;
  localparam logic [17:0] DECI = 18'b000000000_11_00_0010_1;
  localparam logic [17:0] MADR = 18'b000000001_10_00_0010_0;
  localparam logic [17:0] MRD  = 18'b100001000_00_00_0010_0;
  localparam logic [17:0] MWB  = 18'b000100100_00_00_0010_0;
  localparam logic [17:0] MWR  = 18'b110001000_00_00_0010_0;
  localparam logic [17:0] RTWB = 18'b000100010_00_00_0010_0;
  localparam logic [17:0] AIEX = 18'b000000001_10_00_0010_0;
  localparam logic [17:0] AIWB = 18'b000100000_00_00_0010_0;
  localparam logic [17:0] JMP  = 18'b000010000_00_10_0010_0;

  function automatic logic [17:0] rtex(input logic [3:0] code);
    return {9'b000000001, 2'b00, 2'b00, code, 1'b0};
  endfunction

  function automatic logic [17:0] br(input logic p);
    return {4'b0000, p, 4'b0001, 2'b00, 2'b01, 4'b0110, 1'b0};
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
    #3;
    n_tests++;
    if (ctl !== RST) begin
      n_fail++;
      $display("FAIL reset_hold: got %b expected %b", ctl, RST);
    end
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    n_tests++;
    if (ctl !== F1) begin
      n_fail++;
      $display("FAIL reset_release_fetch: got %b expected %b", ctl, F1);
    end
  endtask

  task automatic test_lw_stall();
    logic [17:0] e [8];
    bit r [8];
    e = '{F1, DEC, MADR, MRD, MRD, MRD, MWB, F1};
    r = '{1, 1, 1, 0, 0, 1, 1, 1};
    op = 6'b100011; funct = 6'd0; zero = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem_ready = r[i];
      #1;
      n_tests++;
      if (ctl !== e[i]) begin
        n_fail++;
        $display("FAIL lw_stall cycle %0d: got %b expected %b", i, ctl, e[i]);
      end
      if (i < 7) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_rtype_sweep();
    logic [5:0] f [6];
    logic [3:0] c [6];
    logic [17:0] e [5];
    f = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b101011};
    c = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1111};
    op = 6'b000000; mem_ready = 1'b1; zero = 1'b0;
    for (int k = 0; k < 6; k++) begin
      funct = f[k];
      e = '{F1, DEC, rtex(c[k]), RTWB, F1};
      for (int i = 0; i < 5; i++) begin
        #1;
        n_tests++;
        if (ctl !== e[i]) begin
          n_fail++;
          $display("FAIL rtype funct=%b cycle %0d: got %b expected %b", f[k], i, ctl, e[i]);
        end
        if (i < 4) begin @(posedge clk); #1; end
      end
    end
  endtask

  task automatic test_branch();
    logic [5:0] o [4];
    bit z [4];
    bit p [4];
    logic [17:0] e [4];
    o = '{6'b000100, 6'b000100, 6'b000101, 6'b000101};
    z = '{1, 0, 1, 0};
    p = '{1, 0, 0, 1};
    funct = 6'd0; mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      op = o[k]; zero = z[k];
      e = '{F1, DEC, br(p[k]), F1};
      for (int i = 0; i < 4; i++) begin
        #1;
        n_tests++;
        if (ctl !== e[i]) begin
          n_fail++;
          $display("FAIL branch op=%b zero=%0d cycle %0d: got %b expected %b", o[k], z[k], i, ctl, e[i]);
        end
        if (i < 3) begin @(posedge clk); #1; end
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_jump_addi();
    logic [17:0] ej [4];
    logic [17:0] ea [5];
    ej = '{F1, DEC, JMP, F1};
    ea = '{F1, DEC, AIEX, AIWB, F1};
    op = 6'b000010; funct = 6'd0; mem_ready = 1'b1; zero = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++;
      if (ctl !== ej[i]) begin
        n_fail++;
        $display("FAIL jump cycle %0d: got %b expected %b", i, ctl, ej[i]);
      end
      if (i < 3) begin @(posedge clk); #1; end
    end
    op = 6'b001000;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++;
      if (ctl !== ea[i]) begin
        n_fail++;
        $display("FAIL addi cycle %0d: got %b expected %b", i, ctl, ea[i]);
      end
      if (i < 4) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_illegal();
    logic [5:0] o [2];
    logic [17:0] e [3];
    o = '{6'b111111, 6'b000000};
    e = '{F1, DECI, F1};
    funct = 6'b000000; mem_ready = 1'b1; zero = 1'b0;
    for (int k = 0; k < 2; k++) begin
      op = o[k];
      for (int i = 0; i < 3; i++) begin
        #1;
        n_tests++;
        if (ctl !== e[i]) begin
          n_fail++;
          $display("FAIL illegal op=%b cycle %0d: got %b expected %b", o[k], i, ctl, e[i]);
        end
        if (i < 2) begin @(posedge clk); #1; end
      end
    end
  endtask

  task automatic test_back_to_back();
    // stalled fetch, then sw whose write stalls once
    logic [17:0] e [8];
    bit r [8];
    e = '{F0, F0, F1, DEC, MADR, MWR, MWR, F1};
    r = '{0, 0, 1, 1, 1, 0, 1, 1};
    op = 6'b101011; funct = 6'd0; zero = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem_ready = r[i];
      #1;
      n_tests++;
      if (ctl !== e[i]) begin
        n_fail++;
        $display("FAIL sw_stall cycle %0d: got %b expected %b", i, ctl, e[i]);
      end
      if (i < 7) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_reset_mid_stall();
    logic [17:0] e [5];
    bit r [5];
    e = '{F1, DEC, MADR, MWR, MWR};
    r = '{1, 1, 1, 0, 0};
    op = 6'b101011; funct = 6'd0; zero = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem_ready = r[i];
      #1;
      n_tests++;
      if (ctl !== e[i]) begin
        n_fail++;
        $display("FAIL reset_mid_stall cycle %0d: got %b expected %b", i, ctl, e[i]);
      end
      if (i < 4) begin @(posedge clk); #1; end
    end
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (memwrite !== 1'b0 || ctl !== RST) begin
      n_fail++;
      $display("FAIL reset_in_memwr: got %b expected %b", ctl, RST);
    end
    @(posedge clk); #1;
    n_tests++;
    if (ctl !== RST) begin
      n_fail++;
      $display("FAIL reset_held_after_edge: got %b expected %b", ctl, RST);
    end
    mem_ready = 1'b1;
    reset_n = 1'b1;
    #1;
    n_tests++;
    if (ctl !== F1) begin
      n_fail++;
      $display("FAIL fetch_after_release: got %b expected %b", ctl, F1);
    end
  endtask

  initial begin
    test_reset();
    test_lw_stall();
    test_rtype_sweep();
    test_branch();
    test_jump_addi();
    test_illegal();
    test_back_to_back();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
